// File: rtl/pipe_sequencer.sv
// pipe_sequencer: central pipeline controller for the 5-stage MIPS core.
// Sequences the post-reset drain, hazard stalls, taken-branch flushes and
// multi-cycle mul/div waits. It also keeps stall/flush performance counters
// and a watchdog that traps a hazard stall that never clears.
module pipe_sequencer #(
  parameter int INIT_CYCLES = 4,
  parameter int MAX_STALL   = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_done,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             ready,
  output logic             timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The hazard-run counter only has to reach MAX_STALL-1.
  localparam int HR_W = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;

  localparam logic [3:0]      INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [HR_W-1:0] HR_LAST   = HR_W'(MAX_STALL - 1);
  localparam logic [HR_W-1:0] HR_ONE    = HR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_MD_WAIT,
    ST_TIMEOUT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      init_cnt;
  logic [3:0]      init_cnt_nxt;
  logic [HR_W-1:0] hazard_run;
  logic [HR_W-1:0] hazard_run_nxt;
  logic            flush_evt;
  logic            stall_evt;
  logic            md_issue;

  // A mul/div op holds the front end only when its result is not ready in the same cycle.
  assign md_issue = md_start && !md_done;

  // A stall cycle is any cycle in which RUN or MD_WAIT holds the PC.
  assign stall_evt = ((state == ST_RUN) || (state == ST_MD_WAIT)) && !pc_we;

  // State, drain counter and hazard-run counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      init_cnt   <= 4'd0;
      hazard_run <= '0;
    end else begin
      state      <= state_nxt;
      init_cnt   <= init_cnt_nxt;
      hazard_run <= hazard_run_nxt;
    end
  end

  // Next-state logic and same-cycle pipeline control outputs.
  always_comb begin
    state_nxt      = state;
    init_cnt_nxt   = init_cnt;
    hazard_run_nxt = hazard_run;
    flush_evt      = 1'b0;
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    idex_we        = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    ready          = 1'b0;

    unique case (state)
      ST_INIT: begin
        pc_we        = 1'b0;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        exmem_flush  = 1'b1;
        init_cnt_nxt = init_cnt + 4'd1;
        if (init_cnt == INIT_LAST) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        ready = 1'b1;
        if (md_issue) begin
          pc_we          = 1'b0;
          ifid_we        = 1'b0;
          idex_we        = 1'b0;
          exmem_flush    = 1'b1;
          hazard_run_nxt = '0;
          state_nxt      = ST_MD_WAIT;
        end else if (branch_taken) begin
          ifid_flush     = 1'b1;
          idex_flush     = 1'b1;
          flush_evt      = 1'b1;
          hazard_run_nxt = '0;
        end else if (!stall) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          if (hazard_run == HR_LAST) begin
            state_nxt = ST_TIMEOUT;
          end else begin
            hazard_run_nxt = hazard_run + HR_ONE;
          end
        end else begin
          hazard_run_nxt = '0;
        end
      end

      ST_MD_WAIT: begin
        if (!md_done) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_flush = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end

      ST_TIMEOUT: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_we = 1'b0;
      end

      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Sticky deadlock flag, raised together with the entry into TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (state_nxt == ST_TIMEOUT) begin
      timeout <= 1'b1;
    end
  end

  // Saturating performance counters for stall cycles and branch flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_evt && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Consumes the active-low hazard signal from the stall unit, branch/jump resolution from EX, and a multi-cycle mul/div unit handshake.
- Drives the PC and pipeline-register write enables and flushes.
- Provides post-reset pipeline drain, stall/flush performance counters and a hazard-deadlock watchdog.

Parameters:
- INIT_CYCLES, 4: cycles spent draining bubbles after reset. Legal range 1..15.
- MAX_STALL, 64: consecutive RUN hazard-stall cycles that trigger timeout. Must be ≥2.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  from the stall unit; 1 = no hazard, 0 = data hazard (hold ID).
- branch_taken  in  1  branch/jump in EX resolved taken this cycle.
- md_start  in  1  mul/div op present in EX and issuing this cycle.
- md_done  in  1  mul/div result valid this cycle.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to 32'b0 (nop).
- idex_we  out  1  ID/EX register write enable.
- idex_flush  out  1  load bubble (IR=0) into ID/EX.
- exmem_flush  out  1  load bubble into EX/MEM.
- ready  out  1  1 when in RUN.
- timeout  out  1  sticky hazard-deadlock error.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0 in RUN/MD_WAIT.
- flush_cnt  out  CNT_W  saturating count of taken-branch flushes.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-high, and is the only asynchronous input.
- State and counters: state, init counter, hazard-run counter, stall_cnt, flush_cnt and timeout are registered. All other outputs are combinational from the current state and inputs (same-cycle stall response).
- Defaults (all states, unless overridden below): pc_we=1, ifid_we=1, idex_we=1, all flushes 0, ready=0.
- Reset: state=INIT, init counter=0, hazard-run=0, stall_cnt=0, flush_cnt=0, timeout=0. The resulting outputs are the INIT values. Reset asserted mid-operation (any state) returns to INIT immediately and discards MD_WAIT.

INIT:
- Outputs: pc_we=0, ifid_flush=1, idex_flush=1, exmem_flush=1.
- Init counter increments each cycle. When it equals INIT_CYCLES-1, next state is RUN.
- All inputs are ignored.

RUN (ready=1), priority highest first:
1. md_start=1 and md_done=0: pc_we=0, ifid_we=0, idex_we=0, exmem_flush=1; next state is MD_WAIT. branch_taken and stall are ignored this cycle.
2. md_start=1 and md_done=1: single-cycle op; behave as if md_start=0 (fall through to 3-5).
3. branch_taken=1: pc_we=1, ifid_flush=1, idex_flush=1, flush_cnt+1. Hazard stall is overridden because the ID instruction is wrong-path. Hazard-run resets to 0.
4. stall=0: pc_we=0, ifid_we=0, idex_flush=1; hazard-run+1. If hazard-run reaches MAX_STALL-1 while stalling this cycle, next state is TIMEOUT.
5. Otherwise: defaults; hazard-run=0.

MD_WAIT:
- md_done=0: pc_we=0, ifid_we=0, idex_we=0, exmem_flush=1.
- md_done=1: defaults (result advances to MEM); next state is RUN. stall and branch_taken are ignored in MD_WAIT.
- No timeout while in MD_WAIT.

TIMEOUT:
- Outputs: timeout=1, pc_we=ifid_we=idex_we=0, all flushes 0.
- Stays in TIMEOUT until reset.

Counters:
- stall_cnt increments in every RUN/MD_WAIT cycle with pc_we=0.
- Both counters saturate at all-ones and never wrap.

Test Plan:
- Reset release, no activity: INIT lasts 4 cycles (pc_we=0, all flushes 1), then ready=1 and pc_we=1 on the 5th cycle. stall_cnt=0.
- stall=0 for 3 cycles in RUN: pc_we=0, ifid_we=0, idex_flush=1 in exactly those 3 cycles, stall_cnt=3, no timeout.
- branch_taken=1 together with stall=0: ifid_flush=1, idex_flush=1, pc_we=1, flush_cnt=1, stall_cnt unchanged. The next cycle with stall=1 has defaults.
- md_start pulse, md_done asserted 5 cycles later: 6 cycles total with pc_we=0 and exmem_flush=1 except the md_done cycle (exmem_flush=0). Returns to RUN; stall_cnt=5. md_start and md_done in the same cycle gives no stall.
- stall held at 0 with MAX_STALL=64: timeout rises after 64 stall cycles and holds with pc_we=0. Asserting reset mid-timeout clears timeout asynchronously and re-enters INIT.
- Saturation (CNT_W=4): 20 taken branches give flush_cnt=15.
